gullfaxi_egress_receiver: RTL and testbench
===========================================

GULLFAXI_EGRESS_RECEIVER -- requirements
Module: gullfaxi_egress_receiver

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
REQ-002 The block SHALL connect to one router output port through these ports:
  O_start  in  1  first byte of a packet; O_length valid this cycle
  O_length  in  6  payload byte count, 1..63
  O_data  in  8  payload byte
  O_end  in  1  last byte of a packet
  O_req  in  1  router requests the port
  O_grant  out  1  receiver grants the port
REQ-003 The block SHALL drive a downstream stream and status through these ports:
  m_valid  out  1  output byte valid
  m_data  out  8  output byte
  m_last  out  1  last byte of a packet
  m_ready  in  1  downstream accepts byte
  err_len  out  1  one-cycle pulse: packet dropped
  pkt_count  out  16  count of good packets forwarded

Function
REQ-004 The block SHALL be store-and-forward, with one 64x8 packet buffer, a 6-bit write pointer, a 6-bit read pointer and a latched 6-bit expected length.
REQ-005 The FSM SHALL have the states IDLE, GRANT, RECV and DRAIN.
REQ-006 IDLE: when O_req=1, the FSM SHALL go to GRANT, and O_grant SHALL be 1 from the next cycle.
REQ-007 GRANT: O_grant SHALL be 1. On O_start=1, the block SHALL latch O_length, write O_data to address 0, set wptr=1 and go to RECV. If O_start=1 and O_end=1 in the same cycle, the block SHALL treat it as a 1-byte packet and do the end check immediately.
REQ-008 RECV: O_grant SHALL be 1. On each cycle, the block SHALL write O_data at wptr and increment wptr. Data bytes SHALL be sampled every cycle with no gaps.
REQ-009 End check on O_end: if the byte count equals the latched length and the length is nonzero, the FSM SHALL go to DRAIN. Otherwise it SHALL pulse err_len for one cycle, discard the packet and go to IDLE.
REQ-010 O_grant SHALL fall in the cycle after O_end is sampled, in all cases.
REQ-011 Overflow: in RECV, if wptr would exceed 63 before O_end, writes SHALL stop, and the packet SHALL be dropped with err_len when O_end arrives.
REQ-012 O_start=1 in RECV SHALL abort the current packet, pulse err_len, and start a new packet from that byte (as in REQ-007).
REQ-013 DRAIN: m_valid=1 and m_data=buf[rptr]. m_last=1 when rptr==length-1.
REQ-014 DRAIN: the read pointer SHALL advance only when m_valid=1 and m_ready=1. m_data/m_last SHALL hold stable while m_ready=0.
REQ-015 DRAIN: on the last byte handshake, the block SHALL increment pkt_count, clear the pointers and go to IDLE. O_req is not granted during DRAIN.
REQ-016 First m_valid SHALL occur in the cycle after O_end is sampled for a good packet. The minimum gap is one IDLE cycle between the last output byte and the next O_grant.
REQ-017 pkt_count SHALL wrap from 0xFFFF to 0x0000.
REQ-018 O_start/O_data/O_end SHALL be ignored in IDLE and DRAIN.
REQ-019 All outputs SHALL be registered or decoded only from state and registers, with no combinational path from inputs to outputs.

Reset
REQ-020 When reset=1 at a clock edge, the block SHALL set: state=IDLE, O_grant=0, m_valid=0, m_last=0, m_data=0, err_len=0, pkt_count=0, and pointers and length to 0.
REQ-021 Reset SHALL take effect mid-packet or mid-drain: the buffered packet SHALL be discarded, there SHALL be no err_len, and pkt_count SHALL be 0.
REQ-022 Buffer contents need not be cleared by reset.

Verification
REQ-023 The bench SHALL cover these scenarios:
- O_req=1, then start with length=4 and data 0x11,0x22,0x33,0x44 with end on 0x44, m_ready=1 -> O_grant rises 1 cycle after O_req; m_data 0x11..0x44 on 4 consecutive cycles; m_last on 0x44; pkt_count=1.
- length=5, but end on the 3rd byte -> err_len pulses 1 cycle; no m_valid; O_grant falls next cycle; pkt_count unchanged.
- 1-byte packet, start=end=1, length=1, data 0xA5 -> one output byte 0xA5 with m_last=1.
- 63-byte packet, m_ready toggling 1/0 -> all 63 bytes output in order, stable while stalled; length=63 with 64 bytes -> err_len.
- reset=1 for 1 cycle during RECV of a 10-byte packet -> all outputs at reset values next cycle; next packet processed correctly.
- pkt_count preloaded near 0xFFFF via 65536 1-byte packets (or forced) -> wraps to 0x0000.

Source files
------------

// File: rtl/gullfaxi_egress_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : gullfaxi_egress_receiver_if
//  Purpose  : Bundles the router output-port signals and the downstream
//             byte stream / status of the egress receiver.
//             master : router/downstream side (drives packet bytes, m_ready)
//             slave  : receiver side (drives grant, stream and status)
//  Revision : 1.0 - initial release
// ============================================================================
interface gullfaxi_egress_receiver_if;
  // router output port
  logic        O_start;
  logic [5:0]  O_length;
  logic [7:0]  O_data;
  logic        O_end;
  logic        O_req;
  logic        O_grant;
  // downstream stream and status
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic        err_len;
  logic [15:0] pkt_count;

  modport master (
    output O_start, O_length, O_data, O_end, O_req, m_ready,
    input  O_grant, m_valid, m_data, m_last, err_len, pkt_count
  );

  modport slave (
    input  O_start, O_length, O_data, O_end, O_req, m_ready,
    output O_grant, m_valid, m_data, m_last, err_len, pkt_count
  );
endinterface
`default_nettype wire

// File: rtl/gullfaxi_egress_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : gullfaxi_egress_receiver
//  Purpose  : Store-and-forward egress receiver. Grants one router output
//             port, buffers a whole packet (up to 63 bytes) in a 64x8 RAM,
//             checks its byte count against the length carried with the
//             start byte, then streams it out with valid/ready. Bad packets
//             are dropped with a one-cycle err_len pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module gullfaxi_egress_receiver (
  input  logic                             clk,
  input  logic                             reset,
  gullfaxi_egress_receiver_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RECV  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int unsigned DEPTH = 64;

  state_t      state;
  logic [7:0]  pkt_buf [DEPTH];
  logic [5:0]  wptr;
  logic [5:0]  rptr;
  logic [5:0]  exp_len;
  // Set once address 63 has been written: any further byte means the
  // packet is longer than the buffer and can only end in a drop.
  logic        overflow;

  // registered outputs
  logic        grant;
  logic        valid;
  logic        last;
  logic [7:0]  dout;
  logic        err;
  logic [15:0] pkt_cnt;

  // decoded helpers
  logic        accepting;
  logic        start_byte;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [6:0]  rx_count;
  logic        len_match;
  logic [5:0]  rptr_next;

  // Decode the buffer write and the end-of-packet length check.
  always_comb begin
    accepting  = (state == GRANT) || (state == RECV);
    start_byte = accepting && bus.O_start;
    // A start byte always lands at address 0, even as a restart in RECV.
    wr_en      = start_byte || ((state == RECV) && !overflow);
    wr_addr    = start_byte ? 6'd0 : wptr;
    // Bytes received including the one being sampled this cycle.
    rx_count   = {1'b0, wptr} + 7'd1;
    len_match  = !overflow && (rx_count == {1'b0, exp_len}) && (exp_len != 6'd0);
    rptr_next  = rptr + 6'd1;
  end

  // Packet buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pkt_buf[wr_addr] <= bus.O_data;
    end
  end

  // Receiver FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wptr     <= 6'd0;
      rptr     <= 6'd0;
      exp_len  <= 6'd0;
      overflow <= 1'b0;
      grant    <= 1'b0;
      valid    <= 1'b0;
      last     <= 1'b0;
      dout     <= 8'd0;
      err      <= 1'b0;
      pkt_cnt  <= 16'd0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.O_req) begin
            state <= GRANT;
            grant <= 1'b1;
          end
        end

        GRANT, RECV: begin
          if (bus.O_start) begin
            // A start while receiving abandons the packet in progress.
            if (state == RECV) begin
              err <= 1'b1;
            end
            exp_len  <= bus.O_length;
            wptr     <= 6'd1;
            overflow <= 1'b0;
            if (bus.O_end) begin
              // Single-byte packet: it is good only if it announced length 1.
              grant <= 1'b0;
              if (bus.O_length == 6'd1) begin
                state <= DRAIN;
                valid <= 1'b1;
                dout  <= bus.O_data;
                last  <= 1'b1;
                rptr  <= 6'd0;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
                wptr  <= 6'd0;
              end
            end else begin
              state <= RECV;
            end
          end else if (state == RECV) begin
            if (!overflow) begin
              wptr <= wptr + 6'd1;
              if (wptr == 6'd63) begin
                overflow <= 1'b1;
              end
            end
            if (bus.O_end) begin
              grant <= 1'b0;
              if (len_match) begin
                // Byte 0 was stored by the start byte in an earlier cycle.
                state <= DRAIN;
                valid <= 1'b1;
                dout  <= pkt_buf[0];
                last  <= (exp_len == 6'd1);
                rptr  <= 6'd0;
              end else begin
                err      <= 1'b1;
                state    <= IDLE;
                wptr     <= 6'd0;
                overflow <= 1'b0;
              end
            end
          end
        end

        DRAIN: begin
          // valid is always high here, so m_ready alone completes a beat.
          if (bus.m_ready) begin
            if (last) begin
              pkt_cnt  <= pkt_cnt + 16'd1;
              rptr     <= 6'd0;
              wptr     <= 6'd0;
              overflow <= 1'b0;
              state    <= IDLE;
              valid    <= 1'b0;
              last     <= 1'b0;
              dout     <= 8'd0;
            end else begin
              rptr <= rptr_next;
              dout <= pkt_buf[rptr_next];
              last <= (rptr_next == (exp_len - 6'd1));
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.O_grant   = grant;
  assign bus.m_valid   = valid;
  assign bus.m_data    = dout;
  assign bus.m_last    = last;
  assign bus.err_len   = err;
  assign bus.pkt_count = pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gullfaxi_egress_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gullfaxi_egress_receiver
//  Purpose  : Self-checking bench for gullfaxi_egress_receiver: a table of
//             packet vectors, hand-written abort/reset/wrap sequences and
//             random packets judged by a packet-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gullfaxi_egress_receiver;

  logic clk = 1'b0;
  logic reset;

  gullfaxi_egress_receiver_if bus();

  gullfaxi_egress_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         n;
    logic [7:0] base;
    logic [7:0] step;
    int         rmode;
    bit         exp_good;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  pdata [0:127];
  int          ready_mode = 0;
  int          err_seen   = 0;
  logic [7:0]  obs_data [$];
  logic        obs_last [$];
  logic [15:0] exp_cnt  = 16'd0;
  bit          stall_pend = 1'b0;
  logic [8:0]  held;
  vec_t        vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready pattern: always, toggling, or random.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ~bus.m_ready;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: collects accepted bytes, counts err_len cycles and
  // checks that a stalled byte is held unchanged.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_pend = 1'b0;
      end else begin
        if (bus.err_len) err_seen++;
        if (stall_pend)
          chk("stall_hold", {22'd0, bus.m_valid, bus.m_last, bus.m_data}, {22'd0, 1'b1, held});
        if (bus.m_valid && bus.m_ready) begin
          obs_data.push_back(bus.m_data);
          obs_last.push_back(bus.m_last);
        end
        stall_pend = bus.m_valid && !bus.m_ready;
        held       = {bus.m_last, bus.m_data};
      end
    end
  end

  task automatic idle_inputs();
    bus.O_req    = 1'b0;
    bus.O_start  = 1'b0;
    bus.O_length = 6'd0;
    bus.O_data   = 8'd0;
    bus.O_end    = 1'b0;
  endtask

  task automatic drive_byte(input bit s, input logic [5:0] l, input logic [7:0] d, input bit e);
    bus.O_req    = 1'b0;
    bus.O_start  = s;
    bus.O_length = l;
    bus.O_data   = d;
    bus.O_end    = e;
    @(posedge clk); #1;
  endtask

  // Request the port from idle; grant must appear exactly one cycle later.
  task automatic req_grant(input string name);
    int waited;
    obs_data.delete();
    obs_last.delete();
    err_seen  = 0;
    bus.O_req = 1'b1;
    waited    = 0;
    while (bus.O_grant !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({name, " grant_latency"}, waited, 1);
  endtask

  // Called right after the cycle in which O_end was sampled.
  task automatic finish_pkt(input string name, input int n, input bit good, input int exp_err);
    int cyc;
    int bad;
    int nlast;
    int lastpos;
    idle_inputs();
    @(negedge clk);
    chk({name, " grant_fall"}, bus.O_grant, 0);
    chk({name, " first_valid"}, bus.m_valid, good);
    cyc = 0;
    while (bus.m_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " drain_timeout"}, bus.m_valid, 0);
    @(posedge clk); #1;
    chk({name, " err_pulses"}, err_seen, exp_err);
    chk({name, " out_count"}, obs_data.size(), good ? n : 0);
    if (good) begin
      bad = 0; nlast = 0; lastpos = -1;
      foreach (obs_data[i]) begin
        if (i < n && obs_data[i] !== pdata[i]) bad++;
        if (obs_last[i]) begin
          nlast++;
          lastpos = i;
        end
      end
      chk({name, " data_mismatches"}, bad, 0);
      chk({name, " last_flags"}, nlast, 1);
      chk({name, " last_pos"}, lastpos, n - 1);
      exp_cnt = exp_cnt + 16'd1;
    end
    chk({name, " pkt_count"}, bus.pkt_count, exp_cnt);
  endtask

  task automatic run_pkt(input string name, input int len, input int n, input bit good);
    req_grant(name);
    for (int i = 0; i < n; i++)
      drive_byte(i == 0, 6'(len), pdata[i], i == n - 1);
    finish_pkt(name, n, good, good ? 0 : 1);
  endtask

  initial begin
    logic [7:0] b;
    int         len;
    int         n;
    int         mode;
    bit         good;

    vecs[0] = '{len:4,  n:4,  base:8'h11, step:8'h11, rmode:0, exp_good:1'b1};
    vecs[1] = '{len:5,  n:3,  base:8'h20, step:8'h01, rmode:0, exp_good:1'b0};
    vecs[2] = '{len:1,  n:1,  base:8'hA5, step:8'h00, rmode:0, exp_good:1'b1};
    vecs[3] = '{len:63, n:63, base:8'h01, step:8'h01, rmode:1, exp_good:1'b1};
    vecs[4] = '{len:63, n:64, base:8'h80, step:8'h03, rmode:0, exp_good:1'b0};
    vecs[5] = '{len:0,  n:1,  base:8'h5A, step:8'h00, rmode:0, exp_good:1'b0};
    vecs[6] = '{len:2,  n:2,  base:8'hFE, step:8'h01, rmode:2, exp_good:1'b1};
    vecs[7] = '{len:3,  n:5,  base:8'h40, step:8'h07, rmode:0, exp_good:1'b0};
    vecs[8] = '{len:63, n:70, base:8'hC0, step:8'h05, rmode:0, exp_good:1'b0};

    idle_inputs();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst O_grant",   bus.O_grant, 0);
    chk("rst m_valid",   bus.m_valid, 0);
    chk("rst m_last",    bus.m_last, 0);
    chk("rst m_data",    bus.m_data, 0);
    chk("rst err_len",   bus.err_len, 0);
    chk("rst pkt_count", bus.pkt_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      b = vecs[v].base;
      for (int i = 0; i < vecs[v].n; i++) begin
        pdata[i] = b;
        b = b + vecs[v].step;
      end
      ready_mode = vecs[v].rmode;
      run_pkt($sformatf("vec%0d", v), vecs[v].len, vecs[v].n, vecs[v].exp_good);
    end

    // Start inside RECV: old packet dropped with err_len, new one kept.
    ready_mode = 0;
    pdata[0] = 8'h60; pdata[1] = 8'h61; pdata[2] = 8'h62;
    req_grant("abort");
    drive_byte(1'b1, 6'd5, 8'h50, 1'b0);
    drive_byte(1'b0, 6'd5, 8'h51, 1'b0);
    drive_byte(1'b1, 6'd3, 8'h60, 1'b0);
    drive_byte(1'b0, 6'd3, 8'h61, 1'b0);
    drive_byte(1'b0, 6'd3, 8'h62, 1'b1);
    finish_pkt("abort", 3, 1'b1, 1);

    // Random packets judged by the length rule.
    for (int r = 0; r < 30; r++) begin
      len  = $urandom_range(1, 63);
      mode = $urandom_range(0, 3);
      if (mode < 2)       n = len;
      else if (mode == 2) n = (len > 1) ? $urandom_range(1, len - 1) : 2;
      else                n = len + $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) begin
        len = 0;
        n   = $urandom_range(1, 4);
      end
      for (int i = 0; i < n; i++) pdata[i] = 8'($urandom);
      ready_mode = $urandom_range(0, 2);
      good = (n == len) && (len >= 1) && (n <= 63);
      run_pkt($sformatf("rand%0d", r), len, n, good);
    end

    // Reset in the middle of a 10-byte packet.
    ready_mode = 0;
    req_grant("midrst");
    for (int i = 0; i < 4; i++) drive_byte(i == 0, 6'd10, 8'(i + 1), 1'b0);
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst O_grant",   bus.O_grant, 0);
    chk("midrst m_valid",   bus.m_valid, 0);
    chk("midrst m_last",    bus.m_last, 0);
    chk("midrst m_data",    bus.m_data, 0);
    chk("midrst err_len",   bus.err_len, 0);
    chk("midrst pkt_count", bus.pkt_count, 0);
    exp_cnt = 16'd0;
    @(posedge clk); #1;
    chk("midrst no_err", err_seen, 0);
    for (int i = 0; i < 10; i++) pdata[i] = 8'(8'h90 + i);
    run_pkt("after_rst", 10, 10, 1'b1);

    // Counter wrap from a preloaded value.
    force dut.pkt_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.pkt_cnt;
    exp_cnt = 16'hFFFE;
    @(posedge clk); #1;
    chk("wrap preload", bus.pkt_count, 16'hFFFE);
    pdata[0] = 8'h3C;
    run_pkt("wrap_ffff", 1, 1, 1'b1);
    run_pkt("wrap_0000", 1, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
